// File: rtl/alu_pkg.sv
// Shared opcode definitions for the 32-bit execute-stage ALU.
package alu_pkg;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t ALU_AND  = 4'b0000;
    localparam alu_op_t ALU_OR   = 4'b0001;
    localparam alu_op_t ALU_NOR  = 4'b0101;
    localparam alu_op_t ALU_ADD  = 4'b0010;
    localparam alu_op_t ALU_ADDU = 4'b1010;
    localparam alu_op_t ALU_SUB  = 4'b0110;
    localparam alu_op_t ALU_SUBU = 4'b1110;
    localparam alu_op_t ALU_SLT  = 4'b0111;
    localparam alu_op_t ALU_SLTU = 4'b1111;
    localparam alu_op_t ALU_SLL  = 4'b1000;
    localparam alu_op_t ALU_SRL  = 4'b1001;

endpackage

// File: rtl/bit32_addsub.sv
// 32-bit adder/subtractor shared by all arithmetic and compare operations.
module bit32_addsub (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic [31:0] sum,
    output logic        cout,
    output logic        ovf
);

    logic [31:0] b_eff_s;
    logic [32:0] full_s;

    // Subtraction is a + ~b + 1, so the carry out means "no borrow".
    assign b_eff_s = sub ? ~b : b;
    assign full_s  = {1'b0, a} + {1'b0, b_eff_s} + {32'd0, sub};
    assign sum     = full_s[31:0];
    assign cout    = full_s[32];
    assign ovf     = (a[31] == b_eff_s[31]) && (sum[31] != a[31]);

endmodule

// File: rtl/bit32_alu_sync.sv
// Registered 32-bit ALU: combinational op mux feeding one output register stage.
module bit32_alu_sync
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  alu_op_t     ALUop,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] r,
    output logic        Z,
    output logic        V,
    output logic        CarryOut
);

    logic        sub_s;
    logic [31:0] sum_s;
    logic        cout_s;
    logic        ovf_s;
    logic [31:0] res_s;
    logic        v_s;
    logic        c_s;

    // Adder runs in subtract mode for SUB/SUBU and both compares.
    always_comb begin
        sub_s = 1'b0;
        case (ALUop)
            ALU_SUB, ALU_SUBU, ALU_SLT, ALU_SLTU: sub_s = 1'b1;
            default:                              sub_s = 1'b0;
        endcase
    end

    bit32_addsub u_addsub (
        .a    (a),
        .b    (b),
        .sub  (sub_s),
        .sum  (sum_s),
        .cout (cout_s),
        .ovf  (ovf_s)
    );

    // Result and flag selection; SLT uses sign XOR overflow so it stays correct on overflow.
    always_comb begin
        res_s = 32'd0;
        v_s   = 1'b0;
        c_s   = 1'b0;
        case (ALUop)
            ALU_AND:  res_s = a & b;
            ALU_OR:   res_s = a | b;
            ALU_NOR:  res_s = ~(a | b);
            ALU_ADD, ALU_SUB: begin
                res_s = sum_s;
                v_s   = ovf_s;
                c_s   = cout_s;
            end
            ALU_ADDU, ALU_SUBU: begin
                res_s = sum_s;
                c_s   = cout_s;
            end
            ALU_SLT:  res_s = {31'd0, sum_s[31] ^ ovf_s};
            ALU_SLTU: res_s = {31'd0, ~cout_s};
            ALU_SLL:  res_s = a << b[4:0];
            ALU_SRL:  res_s = a >> b[4:0];
            default: begin
                res_s = 32'd0;
                v_s   = 1'b0;
                c_s   = 1'b0;
            end
        endcase
    end

    // Output register stage; reset wins over any operation sampled on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r        <= 32'd0;
            Z        <= 1'b0;
            V        <= 1'b0;
            CarryOut <= 1'b0;
        end else begin
            r        <= res_s;
            Z        <= (res_s == 32'd0);
            V        <= v_s;
            CarryOut <= c_s;
        end
    end

endmodule

// File: tb/tb_bit32_alu_sync.sv
// Self-checking bench: random ops checked every cycle against a behavioural model, plus literal directed cases.
module tb_bit32_alu_sync;
    import alu_pkg::*;

    logic        clk;
    logic        rst;
    logic [3:0]  ALUop;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        Z;
    logic        V;
    logic        CarryOut;

    int errors = 0;
    int checks = 0;
    bit check_en = 1'b0;

    bit32_alu_sync dut (
        .clk      (clk),
        .rst      (rst),
        .ALUop    (ALUop),
        .a        (a),
        .b        (b),
        .r        (r),
        .Z        (Z),
        .V        (V),
        .CarryOut (CarryOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns {r, Z, V, C} from the operation rules using plain integer arithmetic.
    function automatic logic [34:0] model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        longint sx;
        longint sy;
        longint ss;
        logic [32:0] us;
        logic [31:0] res;
        logic v;
        logic c;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        res = 32'd0;
        v = 1'b0;
        c = 1'b0;
        case (op)
            4'b0000: res = x & y;
            4'b0001: res = x | y;
            4'b0101: res = ~(x | y);
            4'b0010, 4'b1010: begin
                us  = {1'b0, x} + {1'b0, y};
                res = us[31:0];
                c   = us[32];
                ss  = sx + sy;
                v   = (op == 4'b0010) && (ss > 64'sd2147483647 || ss < -64'sd2147483648);
            end
            4'b0110, 4'b1110: begin
                res = x - y;
                c   = (x >= y);
                ss  = sx - sy;
                v   = (op == 4'b0110) && (ss > 64'sd2147483647 || ss < -64'sd2147483648);
            end
            4'b0111: res = (sx < sy) ? 32'd1 : 32'd0;
            4'b1111: res = (x < y) ? 32'd1 : 32'd0;
            4'b1000: res = x << y[4:0];
            4'b1001: res = x >> y[4:0];
            default: res = 32'd0;
        endcase
        return {res, (res == 32'd0), v, c};
    endfunction

    task automatic chk(input string name, input logic [34:0] act, input logic [34:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got r=%h Z=%b V=%b C=%b, want r=%h Z=%b V=%b C=%b",
                     name, act[34:3], act[2], act[1], act[0], exp[34:3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Compare process: outputs must match the op sampled at this edge and hold until the next one.
    always begin
        logic [34:0] exp_v;
        bit en;
        @(posedge clk);
        en = check_en;
        exp_v = rst ? 35'd0 : model(ALUop, a, b);
        #1;
        if (en) chk("cycle", {r, Z, V, CarryOut}, exp_v);
        @(negedge clk);
        #1;
        if (en) chk("hold", {r, Z, V, CarryOut}, exp_v);
    end

    task automatic drive(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y, input logic rs);
        @(negedge clk);
        ALUop = op;
        a     = x;
        b     = y;
        rst   = rs;
    endtask

    task automatic directed(input string name, input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                            input logic [31:0] er, input logic ez, input logic ev, input logic ec);
        drive(op, x, y, 1'b0);
        @(posedge clk);
        #2;
        chk(name, {r, Z, V, CarryOut}, {er, ez, ev, ec});
    endtask

    function automatic logic [31:0] rnd_operand();
        logic [31:0] corners [5];
        corners[0] = 32'h0000_0000;
        corners[1] = 32'h0000_0001;
        corners[2] = 32'hFFFF_FFFF;
        corners[3] = 32'h8000_0000;
        corners[4] = 32'h7FFF_FFFF;
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        rst   = 1'b1;
        ALUop = ALU_ADD;
        a     = 32'd0;
        b     = 32'd0;
        @(posedge clk);
        @(negedge clk);
        check_en = 1'b1;
        drive(ALU_ADD, 32'd5, 32'd7, 1'b1);
        @(posedge clk);
        #2;
        chk("reset_state", {r, Z, V, CarryOut}, 35'd0);

        directed("sub_2_1",    ALU_SUB,  32'd2, 32'd1, 32'd1, 1'b0, 1'b0, 1'b1);
        directed("sub_1_2",    ALU_SUB,  32'd1, 32'd2, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        directed("sub_big",    ALU_SUB,  32'h8000_FFFF, 32'hC000_AAAA, 32'hC000_5555, 1'b0, 1'b0, 1'b0);
        directed("add_ovf",    ALU_ADD,  32'h5555_5555, 32'h5555_5555, 32'hAAAA_AAAA, 1'b0, 1'b1, 1'b0);
        directed("addu_novf",  ALU_ADDU, 32'h5555_5555, 32'h5555_5555, 32'hAAAA_AAAA, 1'b0, 1'b0, 1'b0);
        directed("add_carry",  ALU_ADD,  32'h8000_FFFF, 32'hC000_AAAA, 32'h4001_AAA9, 1'b0, 1'b1, 1'b1);
        directed("and_zero",   ALU_AND,  32'hAAAA_AAAA, 32'h5555_5555, 32'd0, 1'b1, 1'b0, 1'b0);
        directed("or_ones",    ALU_OR,   32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        directed("nor",        ALU_NOR,  32'h0001_FFFF, 32'h0000_2AAA, 32'hFFFE_0000, 1'b0, 1'b0, 1'b0);
        directed("slt_neg",    ALU_SLT,  32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0);
        directed("sltu_neg",   ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0, 1'b0);
        directed("slt_max",    ALU_SLT,  32'h7FFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0, 1'b0);
        directed("sltu_max",   ALU_SLTU, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0, 1'b0);
        directed("slt_mix",    ALU_SLT,  32'h4000_0551, 32'h80FF_FFFF, 32'd0, 1'b1, 1'b0, 1'b0);
        directed("sltu_mix",   ALU_SLTU, 32'h4000_0551, 32'h80FF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0);
        directed("sll_1",      ALU_SLL,  32'h557F_F87C, 32'd1, 32'hAAFF_F0F8, 1'b0, 1'b0, 1'b0);
        directed("sll_31",     ALU_SLL,  32'h5400_0093, 32'h80FF_FFFF, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
        directed("srl_1",      ALU_SRL,  32'hC000_0041, 32'h8000_0001, 32'h6000_0020, 1'b0, 1'b0, 1'b0);
        directed("undef_0011", 4'b0011,  32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 1'b1, 1'b0, 1'b0);

        drive(ALU_ADD, 32'h7FFF_FFFF, 32'd1, 1'b1);
        @(posedge clk);
        #2;
        chk("rst_during_add", {r, Z, V, CarryOut}, 35'd0);
        directed("after_rst",  ALU_ADD,  32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 400; i++) begin
            drive(4'($urandom_range(0, 15)), rnd_operand(), rnd_operand(), ($urandom_range(0, 24) == 0));
        end
        drive(ALU_AND, 32'd0, 32'd0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        #2;
        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
